// File: rtl/arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and
// round-robin history values.
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2,
        WR_D = 2'd3
    } arb_state_t;

    // Last read requester served.
    localparam logic RR_INSTR = 1'b0;
    localparam logic RR_DATA  = 1'b1;

endpackage

// File: rtl/burst_beat_counter.sv
// Read-burst beat counter with saturation and a sticky length-error flag.
// Ports:
//   clk, arstn  - clock, asynchronous active-low reset
//   clear       - zero the count (asserted on every grant)
//   beat        - one R beat accepted
//   last        - RLAST, qualified by beat
//   active      - a read burst is in progress; beats outside it are ignored
//   beat_cnt    - beats seen in the current burst, saturating at BURST_LEN-1
//   burst_err   - sticky: burst was shorter or longer than BURST_LEN
module burst_beat_counter #(
    parameter int unsigned BURST_LEN = 16,
    localparam int unsigned CNT_W = $clog2(BURST_LEN)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             clear,
    input  logic             beat,
    input  logic             last,
    input  logic             active,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             burst_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    logic at_max_c;
    logic beat_c;

    assign at_max_c = (beat_cnt == CNT_MAX);
    assign beat_c   = active & beat;

    // A good burst presents last exactly when the count has reached its max,
    // so any disagreement between the two is a malformed burst.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            if (clear) begin
                beat_cnt <= '0;
            end else if (beat_c && !at_max_c) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (beat_c && (last != at_max_c)) begin
                burst_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single AXI memory port between I-cache fills, D-cache fills
// and D-cache write-backs, one transaction at a time.
// Ports:
//   clk, arstn                      - clock, asynchronous active-low reset
//   i_instr_req / i_instr_addr      - I-cache fill request and block address
//   i_data_rd_req / i_data_addr     - D-cache fill request and block address
//   i_data_wr_req / i_data_wb_addr  - D-cache write-back request and victim address
//   i_r_beat, i_read_last_axi       - R channel beat accepted, RLAST
//   i_b_resp_axi                    - write response received
//   o_start_read_axi/o_start_write_axi - one-cycle burst start pulses
//   o_axi_addr                      - address of the granted transaction
//   o_*_gnt                         - high for the whole granted transaction
//   o_*_done                        - combinational completion pulse in the exit cycle
//   o_beat_cnt, o_burst_err         - read beat count and sticky burst error
module mem_port_arbiter
    import arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 16
) (
    input  logic                         clk,
    input  logic                         arstn,
    input  logic                         i_instr_req,
    input  logic [ADDR_WIDTH-1:0]        i_instr_addr,
    input  logic                         i_data_rd_req,
    input  logic                         i_data_wr_req,
    input  logic [ADDR_WIDTH-1:0]        i_data_addr,
    input  logic [ADDR_WIDTH-1:0]        i_data_wb_addr,
    input  logic                         i_r_beat,
    input  logic                         i_read_last_axi,
    input  logic                         i_b_resp_axi,
    output logic                         o_start_read_axi,
    output logic                         o_start_write_axi,
    output logic [ADDR_WIDTH-1:0]        o_axi_addr,
    output logic                         o_instr_gnt,
    output logic                         o_data_rd_gnt,
    output logic                         o_data_wr_gnt,
    output logic                         o_instr_done,
    output logic                         o_data_rd_done,
    output logic                         o_data_wr_done,
    output logic [$clog2(BURST_LEN)-1:0] o_beat_cnt,
    output logic                         o_burst_err
);

    arb_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   start_rd_q, start_rd_d;
    logic                   start_wr_q, start_wr_d;
    logic                   rr_last_q, rr_last_d;
    logic                   grant_c;
    logic                   rd_last_c;
    logic                   rd_active_c;

    assign rd_last_c   = i_r_beat & i_read_last_axi;
    assign rd_active_c = (state_q == RD_I) || (state_q == RD_D);

    // Next state, grant-time loads and completion pulses.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        start_rd_d     = 1'b0;
        start_wr_d     = 1'b0;
        rr_last_d      = rr_last_q;
        grant_c        = 1'b0;
        o_instr_done   = 1'b0;
        o_data_rd_done = 1'b0;
        o_data_wr_done = 1'b0;
        case (state_q)
            IDLE: begin
                // Write-back first; between two reads, whoever was not last served.
                if (i_data_wr_req) begin
                    state_d    = WR_D;
                    addr_d     = i_data_wb_addr;
                    start_wr_d = 1'b1;
                    grant_c    = 1'b1;
                end else if (i_instr_req && (!i_data_rd_req || rr_last_q == RR_DATA)) begin
                    state_d    = RD_I;
                    addr_d     = i_instr_addr;
                    start_rd_d = 1'b1;
                    rr_last_d  = RR_INSTR;
                    grant_c    = 1'b1;
                end else if (i_data_rd_req) begin
                    state_d    = RD_D;
                    addr_d     = i_data_addr;
                    start_rd_d = 1'b1;
                    rr_last_d  = RR_DATA;
                    grant_c    = 1'b1;
                end
            end
            RD_I: begin
                if (rd_last_c) begin
                    state_d      = IDLE;
                    o_instr_done = 1'b1;
                end
            end
            RD_D: begin
                if (rd_last_c) begin
                    state_d        = IDLE;
                    o_data_rd_done = 1'b1;
                end
            end
            WR_D: begin
                if (i_b_resp_axi) begin
                    state_d        = IDLE;
                    o_data_wr_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            start_rd_q <= 1'b0;
            start_wr_q <= 1'b0;
            rr_last_q  <= RR_DATA;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            start_rd_q <= start_rd_d;
            start_wr_q <= start_wr_d;
            rr_last_q  <= rr_last_d;
        end
    end

    assign o_start_read_axi  = start_rd_q;
    assign o_start_write_axi = start_wr_q;
    assign o_axi_addr        = addr_q;
    assign o_instr_gnt       = (state_q == RD_I);
    assign o_data_rd_gnt     = (state_q == RD_D);
    assign o_data_wr_gnt     = (state_q == WR_D);

    burst_beat_counter #(
        .BURST_LEN (BURST_LEN)
    ) u_beat_cnt (
        .clk       (clk),
        .arstn     (arstn),
        .clear     (grant_c),
        .beat      (i_r_beat),
        .last      (i_read_last_axi),
        .active    (rd_active_c),
        .beat_cnt  (o_beat_cnt),
        .burst_err (o_burst_err)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a directed vector table, directed
// multi-cycle sequences and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned BL = 16;
    localparam int unsigned CW = $clog2(BL);

    logic          clk = 1'b0;
    logic          arstn;
    logic          i_instr_req, i_data_rd_req, i_data_wr_req;
    logic [AW-1:0] i_instr_addr, i_data_addr, i_data_wb_addr;
    logic          i_r_beat, i_read_last_axi, i_b_resp_axi;
    logic          o_start_read_axi, o_start_write_axi;
    logic [AW-1:0] o_axi_addr;
    logic          o_instr_gnt, o_data_rd_gnt, o_data_wr_gnt;
    logic          o_instr_done, o_data_rd_done, o_data_wr_done;
    logic [CW-1:0] o_beat_cnt;
    logic          o_burst_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
        .clk              (clk),
        .arstn            (arstn),
        .i_instr_req      (i_instr_req),
        .i_instr_addr     (i_instr_addr),
        .i_data_rd_req    (i_data_rd_req),
        .i_data_wr_req    (i_data_wr_req),
        .i_data_addr      (i_data_addr),
        .i_data_wb_addr   (i_data_wb_addr),
        .i_r_beat         (i_r_beat),
        .i_read_last_axi  (i_read_last_axi),
        .i_b_resp_axi     (i_b_resp_axi),
        .o_start_read_axi (o_start_read_axi),
        .o_start_write_axi(o_start_write_axi),
        .o_axi_addr       (o_axi_addr),
        .o_instr_gnt      (o_instr_gnt),
        .o_data_rd_gnt    (o_data_rd_gnt),
        .o_data_wr_gnt    (o_data_wr_gnt),
        .o_instr_done     (o_instr_done),
        .o_data_rd_done   (o_data_rd_done),
        .o_data_wr_done   (o_data_wr_done),
        .o_beat_cnt       (o_beat_cnt),
        .o_burst_err      (o_burst_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the port (0 none, 1 I, 2 D read, 3 D write),
    // how many beats the current read has seen, and the last read requester.
    int          m_owner;
    logic [63:0] m_addr;
    bit          m_srd, m_swr;
    int          m_last_rd;   // 1 = I, 2 = D
    int          m_beats;
    bit          m_err;
    int          m_tgt;
    bit          rand_mode = 1'b0;

    task automatic model_reset();
        m_owner = 0; m_addr = '0; m_srd = 0; m_swr = 0;
        m_last_rd = 2; m_beats = 0; m_err = 0; m_tgt = BL;
    endtask

    function automatic bit exp_done(input int who);
        if (who == 3) return (m_owner == 3) && i_b_resp_axi;
        return (m_owner == who) && i_r_beat && i_read_last_axi;
    endfunction

    task automatic model_advance();
        int pick;
        m_srd = 0; m_swr = 0;
        if (m_owner == 0) begin
            pick = 0;
            if (i_data_wr_req) pick = 3;
            else if (i_instr_req && i_data_rd_req) pick = (m_last_rd == 1) ? 2 : 1;
            else if (i_instr_req) pick = 1;
            else if (i_data_rd_req) pick = 2;
            if (pick != 0) begin
                m_owner = pick;
                m_beats = 0;
                m_addr  = (pick == 3) ? i_data_wb_addr : (pick == 1) ? i_instr_addr : i_data_addr;
                if (pick == 3) m_swr = 1;
                else begin
                    m_srd = 1;
                    m_last_rd = pick;
                    m_tgt = BL;
                    if (rand_mode && $urandom_range(0, 11) == 0)
                        m_tgt = ($urandom_range(0, 1) == 1) ? BL - 3 : BL + 1;
                end
            end
        end else if (m_owner == 3) begin
            if (i_b_resp_axi) m_owner = 0;
        end else if (i_r_beat) begin
            if (i_read_last_axi && m_beats < BL - 1) m_err = 1;
            if (!i_read_last_axi && m_beats >= BL - 1) m_err = 1;
            m_beats++;
            if (i_read_last_axi) m_owner = 0;
        end
    endtask

    task automatic check_outputs();
        int ec;
        ec = (m_beats > BL - 1) ? BL - 1 : m_beats;
        check("instr_gnt",   64'(o_instr_gnt),       64'(m_owner == 1));
        check("data_rd_gnt", 64'(o_data_rd_gnt),     64'(m_owner == 2));
        check("data_wr_gnt", 64'(o_data_wr_gnt),     64'(m_owner == 3));
        check("start_read",  64'(o_start_read_axi),  64'(m_srd));
        check("start_write", 64'(o_start_write_axi), 64'(m_swr));
        check("axi_addr",    o_axi_addr,             m_addr);
        check("instr_done",  64'(o_instr_done),      64'(exp_done(1)));
        check("data_rd_done",64'(o_data_rd_done),    64'(exp_done(2)));
        check("data_wr_done",64'(o_data_wr_done),    64'(exp_done(3)));
        check("beat_cnt",    64'(o_beat_cnt),        64'(ec));
        check("burst_err",   64'(o_burst_err),       64'(m_err));
    endtask

    // Advance model across the coming edge; requesters drop after their done.
    task automatic finish_cycle();
        bit di, dd, dw;
        di = exp_done(1); dd = exp_done(2); dw = exp_done(3);
        model_advance();
        @(posedge clk);
        #1;
        if (di) i_instr_req = 1'b0;
        if (dd) i_data_rd_req = 1'b0;
        if (dw) i_data_wr_req = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        finish_cycle();
    endtask

    task automatic clear_inputs();
        i_instr_req = 0; i_data_rd_req = 0; i_data_wr_req = 0;
        i_r_beat = 0; i_read_last_axi = 0; i_b_resp_axi = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 arstn = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        arstn = 1'b1;
        check_outputs();
        finish_cycle();
    endtask

    task automatic wait_any_gnt();
        int budget = 10;
        while (!(o_instr_gnt || o_data_rd_gnt || o_data_wr_gnt) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("gnt_timeout", 64'(0), 64'(1));
    endtask

    task automatic feed_beats(input int n, input int last_at);
        for (int k = 1; k <= n; k++) begin
            i_r_beat = 1'b1;
            i_read_last_axi = (k == last_at);
            step();
        end
        i_r_beat = 1'b0;
        i_read_last_axi = 1'b0;
    endtask

    typedef struct {
        bit ir, dr, dw, rb, rl, br;
        bit ig, dg, wg, srd, swr, id, dd, wd;
        logic [63:0] addr;
        int cnt;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0,0,0,1,1,1, 0,0,0,0,0,0,0,0, 64'h0,           0};
        vt[1] = '{1,1,1,0,0,0, 0,0,0,0,0,0,0,0, 64'h0,           0};
        vt[2] = '{1,1,1,0,0,0, 0,0,1,0,1,0,0,0, 64'h2000,        0};
        vt[3] = '{1,1,1,0,0,1, 0,0,1,0,0,0,0,1, 64'h2000,        0};
        vt[4] = '{1,1,0,0,0,0, 0,0,0,0,0,0,0,0, 64'h2000,        0};
        vt[5] = '{1,1,0,0,0,0, 1,0,0,1,0,0,0,0, 64'h8000_0040,   0};
        vt[6] = '{1,1,0,1,0,0, 1,0,0,0,0,0,0,0, 64'h8000_0040,   0};
        vt[7] = '{1,1,0,0,0,0, 1,0,0,0,0,0,0,0, 64'h8000_0040,   1};

        arstn = 1'b0;
        clear_inputs();
        i_instr_addr = '0; i_data_addr = '0; i_data_wb_addr = '0;
        model_reset();
        #12 check_outputs();
        @(negedge clk);
        arstn = 1'b1;
        check_outputs();
        finish_cycle();

        // Directed vector table: IDLE strobes, write priority, then I fill start.
        i_instr_addr = 64'h8000_0040; i_data_addr = 64'h1000; i_data_wb_addr = 64'h2000;
        for (int r = 0; r < 8; r++) begin
            i_instr_req = vt[r].ir; i_data_rd_req = vt[r].dr; i_data_wr_req = vt[r].dw;
            i_r_beat = vt[r].rb; i_read_last_axi = vt[r].rl; i_b_resp_axi = vt[r].br;
            @(negedge clk);
            check($sformatf("vec%0d_igaddr", r), o_axi_addr, vt[r].addr);
            check($sformatf("vec%0d_cnt", r), 64'(o_beat_cnt), 64'(vt[r].cnt));
            check($sformatf("vec%0d_gnts", r), 64'({o_instr_gnt, o_data_rd_gnt, o_data_wr_gnt}),
                  64'({vt[r].ig, vt[r].dg, vt[r].wg}));
            check($sformatf("vec%0d_starts", r), 64'({o_start_read_axi, o_start_write_axi}),
                  64'({vt[r].srd, vt[r].swr}));
            check($sformatf("vec%0d_dones", r), 64'({o_instr_done, o_data_rd_done, o_data_wr_done}),
                  64'({vt[r].id, vt[r].dd, vt[r].wd}));
            finish_cycle();
        end
        i_b_resp_axi = 0; i_r_beat = 0; i_read_last_axi = 0;
        // Finish the 16-beat I fill (one beat already taken), then D follows.
        for (int k = 2; k <= 16; k++) begin
            i_r_beat = 1'b1;
            i_read_last_axi = (k == 16);
            if (k == 16) begin
                @(negedge clk);
                check("ifill_done", 64'(o_instr_done), 64'(1));
                check_outputs();
                finish_cycle();
            end else step();
        end
        i_r_beat = 0; i_read_last_axi = 0;
        check("ifill_err", 64'(o_burst_err), 64'(0));
        wait_any_gnt();
        check("ifill_then_d", 64'(o_data_rd_gnt), 64'(1));
        feed_beats(BL, BL);

        // Both reads from reset: I, D, I, D.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            i_instr_req = 1; i_data_rd_req = 1;
            i_instr_addr = 64'h4000 + 64'(p); i_data_addr = 64'h5000 + 64'(p);
            wait_any_gnt();
            check($sformatf("order%0d_i", 2 * p), 64'({o_instr_gnt, o_data_rd_gnt}), 64'b10);
            feed_beats(BL, BL);
            wait_any_gnt();
            check($sformatf("order%0d_d", 2 * p + 1), 64'({o_instr_gnt, o_data_rd_gnt}), 64'b01);
            feed_beats(BL, BL);
        end

        // Write and read together: write first at the victim address.
        i_data_wb_addr = 64'h2000_0080; i_data_addr = 64'h3000_0000;
        i_data_wr_req = 1; i_data_rd_req = 1;
        wait_any_gnt();
        check("wr_first", 64'(o_data_wr_gnt), 64'(1));
        check("wr_addr", o_axi_addr, 64'h2000_0080);
        step(); step();
        i_b_resp_axi = 1; step(); i_b_resp_axi = 0;
        wait_any_gnt();
        check("rd_after_wr", 64'(o_data_rd_gnt), 64'(1));
        feed_beats(BL, BL);

        // Write-back arriving mid-read waits, then beats both reads.
        i_instr_req = 1;
        wait_any_gnt();
        feed_beats(5, 0);
        i_data_wr_req = 1; i_data_rd_req = 1;
        feed_beats(BL - 5, BL - 5);
        wait_any_gnt();
        check("wb_waits", 64'(o_data_wr_gnt), 64'(1));
        i_b_resp_axi = 1; step(); i_b_resp_axi = 0;
        wait_any_gnt();
        feed_beats(BL, BL);

        // Short burst sets the sticky error; it survives a good burst.
        do_reset();
        i_instr_req = 1;
        wait_any_gnt();
        feed_beats(10, 10);
        check("short_err", 64'(o_burst_err), 64'(1));
        i_data_rd_req = 1;
        wait_any_gnt();
        feed_beats(BL, BL);
        check("err_sticky", 64'(o_burst_err), 64'(1));

        // Long burst: 17 beats.
        do_reset();
        i_instr_req = 1;
        wait_any_gnt();
        feed_beats(BL + 1, BL + 1);
        check("long_err", 64'(o_burst_err), 64'(1));

        // Reset at beat 5 of a D fill.
        do_reset();
        i_data_rd_req = 1;
        wait_any_gnt();
        feed_beats(4, 0);
        i_r_beat = 1; i_read_last_axi = 1;
        #2 arstn = 1'b0;
        #1 model_reset();
        check("rst_no_done", 64'(o_data_rd_done), 64'(0));
        check("rst_cnt", 64'(o_beat_cnt), 64'(0));
        check_outputs();
        i_r_beat = 0; i_read_last_axi = 0; i_data_rd_req = 0; i_instr_req = 1;
        @(negedge clk);
        arstn = 1'b1;
        check_outputs();
        finish_cycle();
        check("rst_then_i", 64'(o_instr_gnt), 64'(1));
        feed_beats(BL, BL);

        // Randomized traffic.
        do_reset();
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!i_instr_req && $urandom_range(0, 5) == 0) begin
                i_instr_req = 1; i_instr_addr = {$urandom, $urandom};
            end
            if (!i_data_rd_req && $urandom_range(0, 5) == 0) begin
                i_data_rd_req = 1; i_data_addr = {$urandom, $urandom};
            end
            if (!i_data_wr_req && $urandom_range(0, 11) == 0) begin
                i_data_wr_req = 1; i_data_wb_addr = {$urandom, $urandom};
            end
            if (m_owner == 1 || m_owner == 2) begin
                i_r_beat = ($urandom_range(0, 2) != 0);
                i_read_last_axi = i_r_beat && (m_beats + 1 == m_tgt);
            end else begin
                i_r_beat = ($urandom_range(0, 3) == 0);
                i_read_last_axi = ($urandom_range(0, 1) == 1);
            end
            i_b_resp_axi = (m_owner == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
